fetch_wait_stage: RTL and testbench

- IF_wait stage, directly downstream of the fetch request stage and upstream of decode.
- Accepts one entry per handshake from fetch: pc, cancelled flag and exception info.
- Matches in-order instruction-memory responses (inst_data_ok/inst_rdata) to those entries and buffers them in a small FIFO.
- Delivers completed, non-cancelled entries to decode in program order; silently drops entries cancelled by commit/flush after their response drains.

---
 rtl/fetch_wait_stage_if.sv | 32 +++
 rtl/fetch_wait_stage.sv | 117 +++++++++++
 tb/tb_fetch_wait_stage.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_wait_stage_if.sv
// Handshake bundle around the IF_wait stage: fetch entry, memory response, decode delivery.
interface fetch_wait_stage_if;
   logic        valid_i;
   logic [31:0] pc_i;
   logic        cancelled_i;
   logic        exc_i;
   logic        exc_miss_i;
   logic [4:0]  exccode_i;
   logic        ready_o;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        commit_i;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        exc_o;
   logic        exc_miss_o;
   logic [4:0]  exccode_o;
   logic        ready_i;

   modport slave (
      input  valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
      input  inst_data_ok, inst_rdata, commit_i, ready_i,
      output ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o
   );

   modport master (
      output valid_i, pc_i, cancelled_i, exc_i, exc_miss_i, exccode_i,
      output inst_data_ok, inst_rdata, commit_i, ready_i,
      input  ready_o, valid_o, pc_o, inst_o, exc_o, exc_miss_o, exccode_o
   );
endinterface

// File: rtl/fetch_wait_stage.sv
// IF_wait stage: pairs in-order imem responses with fetched entries and hands
// completed, non-cancelled entries to decode in program order.
module fetch_wait_stage #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   fetch_wait_stage_if.slave  bus
);

   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        exc;
      logic        exc_miss;
      logic [4:0]  exccode;
      logic        need_data;
      logic        got_data;
      logic [31:0] inst;
      logic        discard;
   } entry_t;

   entry_t               ent_q [DEPTH];
   logic [PTR_W-1:0]     head_q, tail_q;
   logic [CNT_W-1:0]     count_q, count_d;

   entry_t               head_e, new_e;
   logic                 enq, pop, head_done, wait_found, rsp_wr, bypass;
   logic [PTR_W-1:0]     rsp_idx, scan_idx;

   assign head_e    = ent_q[head_q];
   assign head_done = (count_q != '0) && (!head_e.need_data || head_e.got_data);

   assign bus.ready_o    = (count_q != CNT_W'(DEPTH));
   assign bus.valid_o    = head_done && !head_e.discard && !bus.commit_i;
   assign bus.pc_o       = head_e.pc;
   assign bus.inst_o     = head_e.exc ? 32'h0 : head_e.inst;
   assign bus.exc_o      = head_e.exc;
   assign bus.exc_miss_o = head_e.exc_miss;
   assign bus.exccode_o  = head_e.exccode;

   assign enq = bus.valid_i && bus.ready_o;
   assign pop = (bus.valid_o && bus.ready_i) || (head_done && head_e.discard);

   // Oldest stored entry still waiting on memory; exception entries are skipped.
   always_comb begin
      wait_found = 1'b0;
      rsp_idx    = head_q;
      scan_idx   = head_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         scan_idx = head_q + PTR_W'(i);
         if (!wait_found && (CNT_W'(i) < count_q) &&
             ent_q[scan_idx].need_data && !ent_q[scan_idx].got_data) begin
            wait_found = 1'b1;
            rsp_idx    = scan_idx;
         end
      end
   end

   // A response with nothing stored outstanding belongs to the entry arriving now.
   assign rsp_wr = bus.inst_data_ok && wait_found;
   assign bypass = bus.inst_data_ok && !wait_found && enq && !bus.exc_i;

   always_comb begin
      new_e           = '0;
      new_e.pc        = bus.pc_i;
      new_e.exc       = bus.exc_i;
      new_e.exc_miss  = bus.exc_miss_i;
      new_e.exccode   = bus.exccode_i;
      new_e.need_data = !bus.exc_i;
      new_e.got_data  = bypass;
      new_e.inst      = bypass ? bus.inst_rdata : 32'h0;
      new_e.discard   = bus.cancelled_i || bus.commit_i;
   end

   always_comb begin
      count_d = count_q;
      unique case ({enq, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         if (bus.commit_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
               ent_q[i].discard <= 1'b1;
            end
         end
         if (rsp_wr) begin
            ent_q[rsp_idx].inst     <= bus.inst_rdata;
            ent_q[rsp_idx].got_data <= 1'b1;
         end
         // The tail slot is free when enq fires, so this write is never overlapped.
         if (enq) begin
            ent_q[tail_q] <= new_e;
            tail_q        <= tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_q <= head_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_fetch_wait_stage.sv
// Directed bench for fetch_wait_stage with hand-computed expectations.
module tb_fetch_wait_stage;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   fetch_wait_stage_if bus ();

   fetch_wait_stage #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.valid_i      = 1'b0;
      bus.pc_i         = 32'h0;
      bus.cancelled_i  = 1'b0;
      bus.exc_i        = 1'b0;
      bus.exc_miss_i   = 1'b0;
      bus.exccode_i    = 5'd0;
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
      bus.commit_i     = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic ok, input logic [31:0] rdata);
      idle();
      bus.valid_i      = 1'b1;
      bus.pc_i         = pc;
      bus.inst_data_ok = ok;
      bus.inst_rdata   = rdata;
   endtask

   task automatic rsp(input logic [31:0] rdata);
      idle();
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = rdata;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      idle();
      bus.ready_i = 1'b1;
      reset = 1'b1;
      #1;
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_pc", bus.pc_o, 32'h0);
      chk("rst_inst", bus.inst_o, 32'h0);
      chk("rst_exccode", 32'(bus.exccode_o), 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // 1: same-cycle response, delivered next cycle
      fetch(32'hBFC0_0000, 1'b1, 32'h3C08_0001);
      tick();
      idle();
      chk("t1_valid", 32'(bus.valid_o), 32'd1);
      chk("t1_pc", bus.pc_o, 32'hBFC0_0000);
      chk("t1_inst", bus.inst_o, 32'h3C08_0001);
      chk("t1_exc", 32'(bus.exc_o), 32'd0);
      tick();
      chk("t1_count", 32'(dut.count_q), 32'd0);
      chk("t1_valid_after", 32'(bus.valid_o), 32'd0);

      // 2: fill to DEPTH with decode stalled, then drain back-to-back
      bus.ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         fetch(32'h10 + 32'(4 * k), 1'b1, 32'hA0 + 32'(k));
         chk("t2_ready_fill", 32'(bus.ready_o), 32'd1);
         tick();
      end
      idle();
      chk("t2_ready_full", 32'(bus.ready_o), 32'd0);
      chk("t2_count_full", 32'(dut.count_q), 32'd4);
      bus.ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t2_valid", 32'(bus.valid_o), 32'd1);
         chk("t2_pc", bus.pc_o, 32'h10 + 32'(4 * k));
         chk("t2_inst", bus.inst_o, 32'hA0 + 32'(k));
         tick();
         if (k == 0) chk("t2_ready_after_pop", 32'(bus.ready_o), 32'd1);
      end
      chk("t2_valid_end", 32'(bus.valid_o), 32'd0);
      chk("t2_count_end", 32'(dut.count_q), 32'd0);

      // 3: commit while two fetches await data; their responses drain silently
      fetch(32'h100, 1'b0, 32'h0);
      tick();
      fetch(32'h104, 1'b0, 32'h0);
      tick();
      idle();
      bus.commit_i = 1'b1;
      chk("t3_valid_commit", 32'(bus.valid_o), 32'd0);
      tick();
      rsp(32'hDEAD_0001);
      chk("t3_valid_a", 32'(bus.valid_o), 32'd0);
      tick();
      rsp(32'hDEAD_0002);
      chk("t3_valid_b", 32'(bus.valid_o), 32'd0);
      tick();
      idle();
      chk("t3_valid_c", 32'(bus.valid_o), 32'd0);
      tick();
      chk("t3_count", 32'(dut.count_q), 32'd0);
      fetch(32'h200, 1'b1, 32'h0200_AAAA);
      tick();
      idle();
      chk("t3_next_valid", 32'(bus.valid_o), 32'd1);
      chk("t3_next_pc", bus.pc_o, 32'h200);
      chk("t3_next_inst", bus.inst_o, 32'h0200_AAAA);
      tick();

      // 4: exception entry queued behind a slow fetch keeps order
      fetch(32'h100, 1'b0, 32'h0);
      tick();
      idle();
      bus.valid_i    = 1'b1;
      bus.pc_i       = 32'h104;
      bus.exc_i      = 1'b1;
      bus.exc_miss_i = 1'b1;
      bus.exccode_i  = 5'd2;
      tick();
      idle();
      chk("t4_wait", 32'(bus.valid_o), 32'd0);
      tick();
      rsp(32'h1111_2222);
      chk("t4_wait_rsp", 32'(bus.valid_o), 32'd0);
      tick();
      idle();
      chk("t4_first_valid", 32'(bus.valid_o), 32'd1);
      chk("t4_first_pc", bus.pc_o, 32'h100);
      chk("t4_first_inst", bus.inst_o, 32'h1111_2222);
      chk("t4_first_exc", 32'(bus.exc_o), 32'd0);
      tick();
      chk("t4_exc_valid", 32'(bus.valid_o), 32'd1);
      chk("t4_exc_pc", bus.pc_o, 32'h104);
      chk("t4_exc_flag", 32'(bus.exc_o), 32'd1);
      chk("t4_exc_miss", 32'(bus.exc_miss_o), 32'd1);
      chk("t4_exccode", 32'(bus.exccode_o), 32'd2);
      chk("t4_exc_inst", bus.inst_o, 32'h0);
      tick();
      chk("t4_end", 32'(bus.valid_o), 32'd0);

      // 5: cancelled entry consumes its own response only
      fetch(32'h300, 1'b1, 32'hBAD0_BAD0);
      bus.cancelled_i = 1'b1;
      tick();
      fetch(32'h304, 1'b0, 32'h0);
      chk("t5_cancel_hidden", 32'(bus.valid_o), 32'd0);
      tick();
      rsp(32'h600D_600D);
      chk("t5_wait", 32'(bus.valid_o), 32'd0);
      tick();
      idle();
      chk("t5_valid", 32'(bus.valid_o), 32'd1);
      chk("t5_pc", bus.pc_o, 32'h304);
      chk("t5_inst", bus.inst_o, 32'h600D_600D);
      tick();

      // 6: async reset with three entries stored
      bus.ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         fetch(32'h500 + 32'(4 * k), 1'b1, 32'h5000 + 32'(k));
         tick();
      end
      idle();
      chk("t6_pre_valid", 32'(bus.valid_o), 32'd1);
      chk("t6_pre_count", 32'(dut.count_q), 32'd3);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_valid", 32'(bus.valid_o), 32'd0);
      chk("t6_rst_ready", 32'(bus.ready_o), 32'd1);
      chk("t6_rst_count", 32'(dut.count_q), 32'd0);
      chk("t6_rst_pc", bus.pc_o, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      bus.ready_i = 1'b1;
      tick();
      fetch(32'h400, 1'b1, 32'h0400_0400);
      tick();
      idle();
      chk("t6_after_valid", 32'(bus.valid_o), 32'd1);
      chk("t6_after_pc", bus.pc_o, 32'h400);
      chk("t6_after_inst", bus.inst_o, 32'h0400_0400);
      tick();
      chk("t6_after_count", 32'(dut.count_q), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
